serial_tx: RTL and testbench

- UART-style serial transmitter for the display link, on the same oversample clock as the link's receiver.
- Frame: 1 start bit (low), 8 data bits LSB first, 1 even-parity bit (parity bit = XOR of the data), 1 stop bit (high).
- Each bit is held for CLKS_PER_BIT clocks, followed by a mandatory high idle gap so the receiver re-synchronises on every frame.
- Fed by a valid/ready byte interface from the speed-formatting logic.

---
 rtl/serial_link_pkg.sv | 30 +++
 rtl/serial_tx_fifo.sv | 79 +++++++
 rtl/serial_tx.sv | 228 ++++++++++++++++++++++
 tb/tb_serial_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for the display serial link (transmitter and receiver).
//
// Contents:
//   S_IDLE .. S_GAP   FSM state encodings (3-bit localparams)
//   DATA_BITS         data bits per frame
//   *_LEVEL           line levels for start, stop and idle
//   DEFAULT_CLKS_PER_BIT  bit-cell length in clocks, also used by the receiver
//   parity_of()       parity rule: even parity, so the parity bit is ^data
package serial_link_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  localparam int DEFAULT_CLKS_PER_BIT = 8;

  // Even parity: data bits plus parity bit always hold an even number of ones.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// Small synchronous byte FIFO placed in front of the serial_tx FSM.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears pointers/count)
//   push         write push_data; ignored while full
//   push_data    data to write
//   pop          advance the read pointer; ignored while empty
//   pop_data     head entry (valid whenever !empty)
//   full, empty  registered status flags
//   empty_nxt    value empty will take after this clock edge
//
// DEPTH must be a power of 2 and at least 2, so the pointers wrap naturally.
// A push and a pop in the same cycle are both honoured and the count holds.
module serial_tx_fifo
  import serial_link_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             empty_nxt
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok  = push && !full_q;
    pop_ok   = pop && !empty_q;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    full_d   = (count_d == (AW + 1)'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage carries no reset; only entries behind a valid pointer are read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data  = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign empty_nxt = empty_d;

endmodule

// File: rtl/serial_tx.sv
// UART-style serial transmitter for the display link.
// Frame: start (low), 8 data bits LSB first, even parity, stop (high), then a
// forced high gap of GAP_CYCLES clocks so the receiver re-synchronises.
//
// Ports:
//   clk       bit-cell oversample clock
//   rst_n     asynchronous active-low reset; aborts a frame, line goes high
//   tx_data   byte to send
//   tx_valid  tx_data valid
//   tx_ready  byte accepted on a clock where tx_valid && tx_ready
//   serial    serial line, idles high
//   busy      high from the cycle after accept until the end of the gap
//   done      one-cycle pulse in the last gap cycle
//
// Handshake: a byte transfers on every rising clk edge where tx_valid and
// tx_ready are both high; the source holds tx_data/tx_valid until then.
// tx_data is not sampled at any other time.
//
// Build option SERIAL_TX_FIFO_EN: adds a FIFO_DEPTH-entry byte FIFO
// (serial_tx_fifo) in front of the FSM; tx_ready then means "FIFO not full",
// the FSM pops in S_IDLE, and busy also covers a non-empty FIFO.
// Without it a single latch register feeds the FSM and tx_ready is high
// only in S_IDLE. All outputs come straight from flops.
module serial_tx
  import serial_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int GAP_CYCLES   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       serial,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2 || GAP_CYCLES < 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("serial_tx: illegal parameter values");
    end
  endgenerate

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             serial_q, serial_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Byte source for the FSM: load_valid is only ever high in S_IDLE.
  logic             load_valid;
  logic [7:0]       load_data;
  logic             queued_nxt;

`ifdef SERIAL_TX_FIFO_EN
  logic       fifo_full, fifo_empty, fifo_empty_nxt;
  logic [7:0] fifo_dout;

  serial_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_valid && !fifo_full),
    .push_data (tx_data),
    .pop       (load_valid),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .empty_nxt (fifo_empty_nxt)
  );

  // No bypass: a byte always passes through the FIFO, so a push into an
  // empty FIFO is popped one cycle later and the frame starts after that.
  assign load_valid = (state_q == S_IDLE) && !fifo_empty;
  assign load_data  = fifo_dout;
  assign queued_nxt = !fifo_empty_nxt;
  assign tx_ready   = !fifo_full;
`else
  logic tx_ready_q, tx_ready_d;

  assign load_valid = tx_ready_q && tx_valid;
  assign load_data  = tx_data;
  assign queued_nxt = 1'b0;
  assign tx_ready_d = (state_d == S_IDLE);
  assign tx_ready   = tx_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready_q <= 1'b1;
    end else begin
      tx_ready_q <= tx_ready_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    gap_d     = gap_q;
    shift_d   = shift_q;
    parity_d  = parity_q;

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        gap_d     = '0;
        if (load_valid) begin
          shift_d  = load_data;
          parity_d = parity_of(load_data);
          state_d  = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == BIT_LAST) begin
            bit_idx_d = '0;
            state_d   = S_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        bit_idx_d = '0;
        gap_d     = '0;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state; this
    // makes serial fall in the cycle right after the byte is loaded.
    case (state_d)
      S_START:  serial_d = START_LEVEL;
      S_DATA:   serial_d = shift_d[0];
      S_PARITY: serial_d = parity_d;
      S_STOP:   serial_d = STOP_LEVEL;
      default:  serial_d = IDLE_LEVEL;
    endcase

    done_d = (state_d == S_GAP) && (gap_d == GAP_LAST);
    busy_d = (state_d != S_IDLE) || queued_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      gap_q     <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      serial_q  <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      gap_q     <= gap_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign serial = serial_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: cycle-exact waveform of one frame,
// back-to-back spacing, ignored bytes while busy, mid-frame reset, and a
// full 256-value sweep through a loopback receiver model with a scoreboard.
module tb_serial_tx;

  localparam int CPB       = 8;
  localparam int GAP       = 8;
  localparam int FRAME_LEN = 11 * CPB + GAP;
`ifdef SERIAL_TX_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, serial, busy, done;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serial_tx #(
    .CLKS_PER_BIT (CPB),
    .GAP_CYCLES   (GAP),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .serial   (serial),
    .busy     (busy),
    .done     (done)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         n_checks = 0;
  int         n_fails = 0;
  int         rx_count = 0;
  int         sent_count = 0;
  int         aborted = 0;
  int         abort_gen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic drive_byte(input logic [7:0] b, input bit hold);
    int waited = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (tx_ready !== 1'b1) begin
      check_eq("ready_timeout", {31'b0, tx_ready}, 32'd1);
      tx_valid = 1'b0;
      return;
    end
    exp_q.push_back(b);
    sent_count++;
    @(posedge clk);
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int w = 0;
    while (rx_count < n && w < budget) begin
      @(negedge clk);
      w++;
    end
    check_eq("rx_count", rx_count, n);
  endtask

  // Entered at the negedge of the first cycle after accept.
  task automatic check_frame(input logic [7:0] b);
    int   k;
    logic exp_s;
    for (int c = 1; c <= FRAME_LEN + LAT - 1; c++) begin
      k = c - (LAT - 1);
      if (k < 1)               exp_s = 1'b1;
      else if (k <= CPB)       exp_s = 1'b0;
      else if (k <= 9 * CPB)   exp_s = b[(k - CPB - 1) / CPB];
      else if (k <= 10 * CPB)  exp_s = ^b;
      else                     exp_s = 1'b1;
      check_eq("frame_serial", {31'b0, serial}, {31'b0, exp_s});
      check_eq("frame_done", {31'b0, done}, {31'b0, (k == FRAME_LEN)});
      check_eq("frame_busy", {31'b0, busy}, 32'd1);
      @(negedge clk);
    end
    check_eq("post_ready", {31'b0, tx_ready}, 32'd1);
    check_eq("post_busy", {31'b0, busy}, 32'd0);
    check_eq("post_done", {31'b0, done}, 32'd0);
  endtask

  // ---------------- loopback receiver model ----------------
  initial begin : rx_model
    logic [7:0] rx_byte;
    logic [7:0] exp_b;
    logic       par, stop_b, start_b;
    int         gen;
    rx_byte = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && serial === 1'b0) begin
        start_q.push_back(cyc);
        gen = abort_gen;
        repeat (CPB / 2 - 1) @(negedge clk);
        start_b = serial;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx_byte[i] = serial;
        end
        repeat (CPB) @(negedge clk);
        par = serial;
        repeat (CPB) @(negedge clk);
        stop_b = serial;
        if (gen == abort_gen) begin
          if (exp_q.size() == 0) begin
            check_eq("rx_unexpected_frame", 32'(exp_q.size()), 32'd1);
          end else begin
            exp_b = exp_q.pop_front();
            check_eq("rx_byte", {24'b0, rx_byte}, {24'b0, exp_b});
            check_eq("rx_start", {31'b0, start_b}, 32'd0);
            check_eq("rx_parity", {31'b0, par}, {31'b0, ^exp_b});
            check_eq("rx_parity_ok", {31'b0, par ^ (^rx_byte)}, 32'd0);
            check_eq("rx_stop", {31'b0, stop_b}, 32'd1);
            rx_count++;
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main_seq
    int base;
    int s0, s1;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_serial", {31'b0, serial}, 32'd1);
    check_eq("rst_ready", {31'b0, tx_ready}, 32'd1);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame, cycle-exact.
    drive_byte(8'hA5, 1'b0);
    check_frame(8'hA5);
    wait_rx(1, 50);

    // Back-to-back with tx_valid held; data changes right after each accept.
    start_q.delete();
    base = rx_count;
    drive_byte(8'h01, 1'b1);
    drive_byte(8'hFF, 1'b0);
    wait_rx(base + 2, 300);
    if (start_q.size() >= 2) begin
      s0 = start_q.pop_front();
      s1 = start_q.pop_front();
      check_eq("b2b_period", s1 - s0, FRAME_LEN + 1);
    end else begin
      check_eq("b2b_starts", 32'(start_q.size()), 32'd2);
    end

`ifndef SERIAL_TX_FIFO_EN
    // A byte offered mid-frame is ignored.
    base = rx_count;
    drive_byte(8'h96, 1'b0);
    repeat (19) @(negedge clk);
    check_eq("busy_ready_low", {31'b0, tx_ready}, 32'd0);
    check_eq("busy_high", {31'b0, busy}, 32'd1);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_rx(base + 1, 200);
    repeat (200) @(negedge clk);
    check_eq("ignored_no_frame", rx_count, base + 1);
`endif

    // Reset in the middle of a frame.
    base = rx_count;
    drive_byte(8'h77, 1'b0);
    repeat (39) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_serial", {31'b0, serial}, 32'd1);
    check_eq("midrst_busy", {31'b0, busy}, 32'd0);
    check_eq("midrst_ready", {31'b0, tx_ready}, 32'd1);
    check_eq("midrst_done", {31'b0, done}, 32'd0);
    void'(exp_q.pop_back());
    aborted++;
    abort_gen++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check_eq("after_rst_serial", {31'b0, serial}, 32'd1);
    drive_byte(8'h5A, 1'b0);
    wait_rx(base + 1, 300);

`ifdef SERIAL_TX_FIFO_EN
    // Fill the FIFO: first byte is popped at once, so five pushes fill it.
    base = rx_count;
    drive_byte(8'h11, 1'b1);
    drive_byte(8'h22, 1'b1);
    drive_byte(8'h33, 1'b1);
    drive_byte(8'h44, 1'b1);
    drive_byte(8'h55, 1'b1);
    check_eq("fifo_full_ready", {31'b0, tx_ready}, 32'd0);
    drive_byte(8'h66, 1'b0);
    wait_rx(base + 6, 7 * (FRAME_LEN + 2));
`endif

    // Sweep all byte values.
    base = rx_count;
    for (int v = 0; v < 256; v++) begin
      drive_byte(8'(v), 1'b0);
    end
    wait_rx(base + 256, 400);

    begin
      int w = 0;
      while (exp_q.size() != 0 && w < 400) begin
        @(negedge clk);
        w++;
      end
    end
    check_eq("rx_drain", 32'(exp_q.size()), 32'd0);
    check_eq("rx_total", rx_count, sent_count - aborted);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
